// File: rtl/btb_update_ctrl.sv
// BTB update controller: buffers EX-resolved branch updates in a coalescing queue and
// shares the single BTB write port with cfg preload writes, using a bounded cfg burst.
module btb_update_ctrl #(
  parameter int INDEX_WIDTH = 6,
  parameter int QDEPTH      = 4,
  parameter int CFG_BURST   = 4,
  localparam int TW         = 30 - INDEX_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ex_req_i,
  input  logic [31:0]            ex_pc_i,
  input  logic [31:0]            ex_target_i,
  input  logic                   ex_taken_i,
  input  logic                   ex_hit_i,
  input  logic                   ex_mispred_i,
  output logic                   ex_ready_o,
  input  logic                   cfg_req_i,
  input  logic [31:0]            cfg_pc_i,
  input  logic [31:0]            cfg_target_i,
  input  logic                   cfg_taken_i,
  output logic                   cfg_ready_o,
  input  logic                   flush_i,
  output logic                   btb_wren_o,
  output logic [INDEX_WIDTH-1:0] btb_wr_index_o,
  output logic [TW-1:0]          btb_wr_tag_o,
  output logic [31:0]            btb_wr_target_o,
  output logic                   btb_br_taken_o,
  output logic                   busy_o,
  output logic [15:0]            wr_cnt_o
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CFG_BURST + 1);

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] idx;
    logic [TW-1:0]          tag;
    logic [31:0]            tgt;
    logic                   tk;
  } ent_t;

  ent_t          q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, newest;
  logic [CW-1:0] q_cnt;
  logic [BW-1:0] burst;
  logic          full, empty, cfg_gnt, q_gnt, enq, coal, push;
  ent_t          ex_ent, cfg_ent;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{ex_pc_i[1:0], cfg_pc_i[1:0]};

  assign ex_ent  = '{idx: ex_pc_i[INDEX_WIDTH+1:2], tag: ex_pc_i[31:INDEX_WIDTH+2],
                     tgt: ex_target_i, tk: ex_taken_i};
  assign cfg_ent = '{idx: cfg_pc_i[INDEX_WIDTH+1:2], tag: cfg_pc_i[31:INDEX_WIDTH+2],
                     tgt: cfg_target_i, tk: cfg_taken_i};

  assign full        = (q_cnt == CW'(QDEPTH));
  assign empty       = (q_cnt == '0);
  assign ex_ready_o  = !full;
  assign cfg_gnt     = cfg_req_i && (burst < BW'(CFG_BURST));
  assign cfg_ready_o = cfg_gnt && !rst_i;
  // A flush discards whatever would be granted from the queue this cycle.
  assign q_gnt       = !cfg_gnt && !empty && !flush_i;
  assign busy_o      = !empty || btb_wren_o;

  // Correct predictions (hit and not mispredicted) are accepted but never queued.
  assign enq    = ex_req_i && !full && (ex_mispred_i || !ex_hit_i) && !flush_i;
  assign newest = wr_ptr - PW'(1);
  // Coalescing is only safe when the newest entry survives this cycle's pop.
  assign coal   = enq && !empty && !(q_gnt && q_cnt == CW'(1)) &&
                  (q_mem[newest].idx == ex_ent.idx);
  assign push   = enq && !coal;

  always_ff @(posedge clk_i) begin
    if (push)      q_mem[wr_ptr] <= ex_ent;
    else if (coal) q_mem[newest] <= ex_ent;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      q_cnt           <= '0;
      burst           <= '0;
      btb_wren_o      <= 1'b0;
      btb_wr_index_o  <= '0;
      btb_wr_tag_o    <= '0;
      btb_wr_target_o <= '0;
      btb_br_taken_o  <= 1'b0;
      wr_cnt_o        <= '0;
    end else begin
      btb_wren_o <= cfg_gnt || q_gnt;
      if (cfg_gnt)
        {btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o, btb_br_taken_o} <= cfg_ent;
      else if (q_gnt)
        {btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o, btb_br_taken_o} <= q_mem[rd_ptr];
      if ((cfg_gnt || q_gnt) && wr_cnt_o != 16'hFFFF)
        wr_cnt_o <= wr_cnt_o + 16'd1;

      // Burst only accumulates while cfg is starving a non-empty queue.
      if (flush_i || empty)  burst <= '0;
      else if (cfg_gnt)      burst <= burst + BW'(1);
      else                   burst <= '0;

      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        q_cnt  <= '0;
      end else begin
        if (q_gnt) rd_ptr <= rd_ptr + PW'(1);
        if (push)  wr_ptr <= wr_ptr + PW'(1);
        q_cnt <= q_cnt + CW'(push) - CW'(q_gnt);
      end
    end
  end
endmodule
